// File: rtl/game_input_ctrl.sv
// Button conditioning front end for gameFSM: synchronize, debounce and edge-detect
// three pushbuttons, then gate the resulting pulses by game state with fixed priority.
module game_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       resetFSM,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic [2:0] game_state,
    output logic       startGame,
    output logic       pauseGame,
    output logic       reset,
    output logic [2:0] btn_level
);

    localparam int unsigned NB    = 3;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ST_START    = 3'b000;
    localparam logic [2:0] ST_PLAYING  = 3'b001;
    localparam logic [2:0] ST_PAUSE    = 3'b010;
    localparam logic [2:0] ST_RESET    = 3'b011;
    localparam logic [2:0] ST_GAMEOVER = 3'b100;

    logic [NB-1:0]    pressed_c;
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    stable;
    logic [NB-1:0]    stable_q;
    logic [NB-1:0]    rise_c;
    logic [CNT_W-1:0] cnt [NB];

    logic start_ok_c;
    logic pause_ok_c;
    logic do_reset_c;
    logic do_pause_c;
    logic do_start_c;

    // Bit order {reset, pause, start}; 1 = pressed regardless of board polarity.
    assign pressed_c = {btn_reset, btn_pause, btn_start} ^ {NB{BTN_ACTIVE_LOW}};

    // Two-flop synchronizer; released level is 0 after normalization.
    always_ff @(posedge clk) begin
        if (resetFSM) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pressed_c;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (resetFSM) begin
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < int'(NB); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable_q <= stable;
            for (int i = 0; i < int'(NB); i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise_c    = stable & ~stable_q;
    assign btn_level = stable;

    // State gating and reset > pause > start arbitration.
    always_comb begin
        start_ok_c = 1'b0;
        pause_ok_c = 1'b0;
        case (game_state)
            ST_START, ST_RESET, ST_GAMEOVER: start_ok_c = 1'b1;
            ST_PLAYING, ST_PAUSE:            pause_ok_c = 1'b1;
            default:                         ;
        endcase
        do_reset_c = rise_c[2];
        do_pause_c = rise_c[1] & pause_ok_c & ~do_reset_c;
        do_start_c = rise_c[0] & start_ok_c & ~do_reset_c & ~do_pause_c;
    end

    always_ff @(posedge clk) begin
        if (resetFSM) begin
            startGame <= 1'b0;
            pauseGame <= 1'b0;
            reset     <= 1'b0;
        end else begin
            startGame <= do_start_c;
            pauseGame <= do_pause_c;
            reset     <= do_reset_c;
        end
    end

endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed bench for game_input_ctrl with DEBOUNCE_CYCLES=4 and active-low buttons.
module tb_game_input_ctrl;

    logic       clk = 1'b0;
    logic       resetFSM;
    logic       btn_start;
    logic       btn_pause;
    logic       btn_reset;
    logic [2:0] game_state;
    logic       startGame;
    logic       pauseGame;
    logic       reset;
    logic [2:0] btn_level;

    int checks   = 0;
    int failures = 0;

    game_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .resetFSM  (resetFSM),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .btn_reset (btn_reset),
        .game_state(game_state),
        .startGame (startGame),
        .pauseGame (pauseGame),
        .reset     (reset),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic es, input logic ep, input logic er,
                       input logic [2:0] el);
        checks++;
        assert ({startGame, pauseGame, reset, btn_level} === {es, ep, er, el})
        else begin
            failures++;
            $error("FAIL %s observed start=%b pause=%b reset=%b level=%b expected start=%b pause=%b reset=%b level=%b",
                   tag, startGame, pauseGame, reset, btn_level, es, ep, er, el);
        end
    endtask

    // Release everything and let the debouncers fall back to idle.
    task automatic release_all();
        btn_start = 1'b1;
        btn_pause = 1'b1;
        btn_reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("idle_after_release", 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        // Reset held 3 cycles with every button pressed.
        resetFSM   = 1'b1;
        btn_start  = 1'b0;
        btn_pause  = 1'b0;
        btn_reset  = 1'b0;
        game_state = 3'b000;
        for (int e = 0; e < 3; e++) begin
            step();
            chk("reset_hold", 1'b0, 1'b0, 1'b0, 3'b000);
        end
        resetFSM = 1'b0;
        release_all();

        // Clean start press held 50 cycles.
        for (int e = 0; e < 50; e++) begin
            btn_start = 1'b0;
            step();
            chk("start_clean", e == 6, 1'b0, 1'b0, {2'b00, e >= 5});
        end
        release_all();

        // Bounce every 2 cycles, then settle pressed from index 8.
        for (int e = 0; e < 30; e++) begin
            btn_start = (e < 10) ? 1'((e / 2) % 2) : 1'b0;
            step();
            chk("start_bounce", e == 14, 1'b0, 1'b0, {2'b00, e >= 13});
        end
        release_all();

        // Pause gated off in START state, level still tracks.
        game_state = 3'b000;
        for (int e = 0; e < 10; e++) begin
            btn_pause = 1'b0;
            step();
            chk("pause_gated", 1'b0, 1'b0, 1'b0, {1'b0, e >= 5, 1'b0});
        end
        release_all();

        game_state = 3'b001;
        for (int e = 0; e < 12; e++) begin
            btn_pause = 1'b0;
            step();
            chk("pause_playing", 1'b0, e == 6, 1'b0, {1'b0, e >= 5, 1'b0});
        end
        release_all();

        // Start and reset together in GAMEOVER: reset wins.
        game_state = 3'b100;
        for (int e = 0; e < 12; e++) begin
            btn_start = 1'b0;
            btn_reset = 1'b0;
            step();
            chk("reset_vs_start", 1'b0, 1'b0, e == 6, {e >= 5, 1'b0, e >= 5});
        end
        release_all();

        // Pause and reset together in PLAYING: reset wins.
        game_state = 3'b001;
        for (int e = 0; e < 12; e++) begin
            btn_pause = 1'b0;
            btn_reset = 1'b0;
            step();
            chk("reset_vs_pause", 1'b0, 1'b0, e == 6, {e >= 5, e >= 5, 1'b0});
        end
        release_all();

        // Undefined state code blocks start.
        game_state = 3'b110;
        for (int e = 0; e < 10; e++) begin
            btn_start = 1'b0;
            step();
            chk("start_undef_state", 1'b0, 1'b0, 1'b0, {2'b00, e >= 5});
        end
        release_all();

        // resetFSM mid-count loses the first press; held button re-qualifies.
        game_state = 3'b000;
        for (int e = 0; e < 20; e++) begin
            btn_start = 1'b0;
            resetFSM  = (e == 3);
            step();
            chk("start_mid_reset", e == 10, 1'b0, 1'b0, {2'b00, e >= 9});
        end
        resetFSM = 1'b0;
        release_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_input_ctrl.md
Name: game_input_ctrl

Overview:
Upstream conditioning stage for gameFSM. Takes the three raw pushbuttons (start, pause, reset) and converts each into a clean single-cycle pulse for gameFSM's startGame, pauseGame and reset inputs. Each button passes through a synchronizer, a debouncer and a rising-edge detector. Pulses are gated by the current gameFSM state (its dataout is fed back here), and only one command is issued per cycle, chosen by fixed priority.

Parameters:
DEBOUNCE_CYCLES  1000000  consecutive stable synchronized samples needed to accept a level change (20 ms at 50 MHz); must be >= 1
BTN_ACTIVE_LOW   1        1: raw buttons read 0 when pressed; 0: read 1 when pressed

Ports:
clk         input   1  system clock
resetFSM    input   1  synchronous, active-high reset
btn_start   input   1  raw start button, asynchronous
btn_pause   input   1  raw pause button, asynchronous
btn_reset   input   1  raw game-reset button, asynchronous
game_state  input   3  gameFSM dataout: 000 START, 001 PLAYING, 010 PAUSE, 011 RESET, 100 GAMEOVER
startGame   output  1  one-cycle start command to gameFSM
pauseGame   output  1  one-cycle pause/resume command to gameFSM
reset       output  1  one-cycle game-reset command to gameFSM
btn_level   output  3  debounced pressed levels {reset, pause, start}, 1 = pressed

Behaviour:
- Single clock domain. resetFSM is sampled only on the clk rising edge; when high, all state clears on that edge.
- Reset values: startGame, pauseGame, reset, btn_level = 0; synchronizer flops load the released level; debounce counters = 0; edge history = 0.
- Per button, normalize polarity first: pressed = raw XOR BTN_ACTIVE_LOW.
- Synchronizer: 2 flops, sync1 then sync2. Output s = sync2.
- Debouncer:
  - Holds a stable level L and counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
  - If s == L: cnt <= 0.
  - If s != L and cnt == DEBOUNCE_CYCLES-1: L <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any bounce back to L restarts the count. The counter never wraps.
- Edge detect: raw pulse request = L rising (previous L = 0, new L = 1). Releases generate nothing. Holding a button gives exactly one request.
- State gating (request dropped, not queued, when gated off):
  - start request valid only if game_state is 000, 011 or 100.
  - pause request valid only if game_state is 001 or 010.
  - reset request always valid.
  - Undefined game_state codes (101-111): only reset passes.
- Arbitration among valid requests in the same cycle: reset > pause > start. Losing requests are dropped. At most one output is high in any cycle.
- Outputs are registered. Latency: if the first edge sampling the pressed level is edge 0, the pulse is high after edge DEBOUNCE_CYCLES+2 and low again after edge DEBOUNCE_CYCLES+3.
- btn_level equals L for each button (registered, no gating).
- resetFSM mid-debounce: the count is lost and no pulse is issued. A button still held after resetFSM falls is treated as a new press and pulses after the normal latency.
- Gating uses the game_state value present in the cycle the request is formed.

Test Plan:
- resetFSM high for 3 cycles with all buttons pressed (raw=0) -> startGame, pauseGame, reset and btn_level all 0 throughout.
- DEBOUNCE_CYCLES=4, game_state=000, btn_start held low from edge 0 for 50 cycles -> startGame high for exactly one cycle after edge 6; btn_level[0]=1 from edge 5; no further pulses.
- btn_start toggled every 2 cycles for 10 cycles, then held low -> exactly one startGame pulse, 6 edges after the last transition is first sampled; none during the bounce.
- game_state=000, press pause -> no pauseGame, btn_level[1]=1. Release, set game_state=001, press again -> one pauseGame pulse at latency 6.
- game_state=100, btn_start and btn_reset pressed on the same edge -> reset pulses once, startGame stays 0. With game_state=001, pause and reset pressed together -> only reset.
- btn_start held; resetFSM pulsed at edge 3 (mid-count) -> no pulse from the first press. Button still held: pulse 6 edges after the first post-reset edge.
